// File: rtl/jtkiwi_vtimer_adj.sv
// Kiwi-family video timing: fractional pixel enables, H/V counters, blanking, sync
// and render look-ahead, with H/V sync offsets picked up only at frame boundaries.
module jtkiwi_vtimer_adj #(
  parameter int CEN_N    = 1,
  parameter int CEN_M    = 4,
  parameter int WC       = 4,
  parameter int H_MAX    = 383,
  parameter int HB_START = 255,
  parameter int HS_START = 297,
  parameter int HS_LEN   = 32,
  parameter int V_START  = 16,
  parameter int V_END    = 279,
  parameter int VB_START = 239,
  parameter int VS_START = 254,
  parameter int VS_LEN   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] hs_adj,
  input  logic [2:0] vs_adj,
  input  logic       flip,
  output logic       pxl2_cen,
  output logic       pxl_cen,
  output logic [8:0] hdump,
  output logic [8:0] vdump,
  output logic [8:0] vrender,
  output logic [8:0] vrender1,
  output logic       Hinit,
  output logic       Vinit,
  output logic       LHBL,
  output logic       LVBL,
  output logic       HS,
  output logic       VS,
  output logic       frame
);

  localparam logic [WC-1:0]     CEN_N_W    = WC'(CEN_N);
  localparam logic [WC-1:0]     CEN_M_W    = WC'(CEN_M);
  localparam logic [8:0]        H_MAX_9    = 9'(H_MAX);
  localparam logic [8:0]        V_START_9  = 9'(V_START);
  localparam logic [8:0]        V_END_9    = 9'(V_END);
  localparam logic [8:0]        VS_LEN_9   = 9'(VS_LEN);
  localparam logic [9:0]        H_TOT_W    = 10'(H_MAX + 1);
  localparam logic [9:0]        HB_W       = 10'(HB_START);
  localparam logic [9:0]        HS_LEN_W   = 10'(HS_LEN);
  localparam logic [9:0]        V_START_W  = 10'(V_START);
  localparam logic [9:0]        V_END_W    = 10'(V_END);
  localparam logic [9:0]        VB_W       = 10'(VB_START);
  localparam logic [9:0]        V_FLIP_W   = 10'(V_START + V_END);
  localparam logic signed [9:0] HS_START_S = 10'(HS_START);
  localparam logic signed [9:0] H_TOT_S    = 10'(H_MAX + 1);
  localparam logic signed [9:0] VS_START_S = 10'(VS_START);
  localparam logic signed [9:0] V_START_S  = 10'(V_START);
  localparam logic signed [9:0] V_END_S    = 10'(V_END);
  localparam logic signed [9:0] V_TOT_S    = 10'(V_END - V_START + 1);

  logic [WC-1:0]     acc_r;
  logic              tog_r;
  logic [WC:0]       acc_sum_s;
  logic              cen2_s;
  logic [3:0]        hoff_r;
  logic [2:0]        voff_r;
  logic [8:0]        vs_cnt_r;
  logic [8:0]        vs_cnt_nxt_s;
  logic [8:0]        h_nxt_s;
  logic [8:0]        v_nxt_s;
  logic signed [9:0] hs_sum_s;
  logic signed [9:0] vs_sum_s;
  logic [9:0]        hs0_s;
  logic [9:0]        vs0_s;
  logic [9:0]        hn_s;
  logic [9:0]        hdiff_s;
  logic [9:0]        n1_s;
  logic [9:0]        n2_s;
  logic              hs_nxt_s;
  logic              hs_hit_s;
  logic              vs_nxt_s;
  logic              vinit_nxt_s;

  assign acc_sum_s = {1'b0, acc_r} + {1'b0, CEN_N_W};
  assign cen2_s    = acc_sum_s >= {1'b0, CEN_M_W};

  // Fractional accumulator; pxl_cen rides on every second pxl2_cen pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_r    <= '0;
      tog_r    <= 1'b0;
      pxl2_cen <= 1'b0;
      pxl_cen  <= 1'b0;
    end else if (cen2_s) begin
      acc_r    <= WC'(acc_sum_s - {1'b0, CEN_M_W});
      tog_r    <= ~tog_r;
      pxl2_cen <= 1'b1;
      pxl_cen  <= tog_r;
    end else begin
      acc_r    <= acc_sum_s[WC-1:0];
      pxl2_cen <= 1'b0;
      pxl_cen  <= 1'b0;
    end
  end

  // Next counter values
  always_comb begin
    h_nxt_s = hdump + 9'd1;
    v_nxt_s = vdump;
    if (hdump == H_MAX_9) begin
      h_nxt_s = 9'd0;
      if (vdump == V_END_9) begin
        v_nxt_s = V_START_9;
      end else begin
        v_nxt_s = vdump + 9'd1;
      end
    end else begin
      h_nxt_s = hdump + 9'd1;
    end
  end

  // Effective sync start positions from the frame-latched offsets
  always_comb begin
    hs_sum_s = HS_START_S + $signed({{6{hoff_r[3]}}, hoff_r});
    vs_sum_s = VS_START_S + $signed({{7{voff_r[2]}}, voff_r});
    hs0_s    = hs_sum_s;
    vs0_s    = vs_sum_s;
    if (hs_sum_s < 10'sd0) begin
      hs0_s = 10'(hs_sum_s + H_TOT_S);
    end else if (hs_sum_s >= H_TOT_S) begin
      hs0_s = 10'(hs_sum_s - H_TOT_S);
    end else begin
      hs0_s = hs_sum_s;
    end
    if (vs_sum_s < V_START_S) begin
      vs0_s = 10'(vs_sum_s + V_TOT_S);
    end else if (vs_sum_s > V_END_S) begin
      vs0_s = 10'(vs_sum_s - V_TOT_S);
    end else begin
      vs0_s = vs_sum_s;
    end
  end

  // HS window test (distance past hs0, modulo the line length) and VS line counting
  always_comb begin
    hn_s        = {1'b0, h_nxt_s};
    hdiff_s     = hn_s - hs0_s;
    if (hn_s >= hs0_s) begin
      hdiff_s = hn_s - hs0_s;
    end else begin
      hdiff_s = hn_s + H_TOT_W - hs0_s;
    end
    hs_nxt_s     = hdiff_s < HS_LEN_W;
    hs_hit_s     = hn_s == hs0_s;
    vinit_nxt_s  = (h_nxt_s == H_MAX_9) && (v_nxt_s == V_END_9);
    vs_nxt_s     = VS;
    vs_cnt_nxt_s = vs_cnt_r;
    // Once raised, VS counts hs0 crossings so it always lasts VS_LEN lines
    if (VS) begin
      if (hs_hit_s) begin
        if (vs_cnt_r <= 9'd1) begin
          vs_nxt_s     = 1'b0;
          vs_cnt_nxt_s = 9'd0;
        end else begin
          vs_cnt_nxt_s = vs_cnt_r - 9'd1;
        end
      end else begin
        vs_cnt_nxt_s = vs_cnt_r;
      end
    end else if (hs_hit_s && ({1'b0, v_nxt_s} == vs0_s)) begin
      vs_nxt_s     = 1'b1;
      vs_cnt_nxt_s = VS_LEN_9;
    end else begin
      vs_nxt_s     = 1'b0;
    end
  end

  // Pixel-rate state: counters, blanking, syncs, frame markers and offset latches
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hdump    <= 9'd0;
      vdump    <= V_START_9;
      Hinit    <= 1'b0;
      Vinit    <= 1'b0;
      LHBL     <= 1'b1;
      LVBL     <= 1'b1;
      HS       <= 1'b0;
      VS       <= 1'b0;
      frame    <= 1'b0;
      hoff_r   <= 4'd0;
      voff_r   <= 3'd0;
      vs_cnt_r <= 9'd0;
    end else if (pxl_cen) begin
      hdump    <= h_nxt_s;
      vdump    <= v_nxt_s;
      Hinit    <= h_nxt_s == H_MAX_9;
      Vinit    <= vinit_nxt_s;
      frame    <= frame ^ vinit_nxt_s;
      LHBL     <= {1'b0, h_nxt_s} <= HB_W;
      LVBL     <= ({1'b0, v_nxt_s} >= V_START_W) && ({1'b0, v_nxt_s} <= VB_W);
      HS       <= hs_nxt_s;
      VS       <= vs_nxt_s;
      vs_cnt_r <= vs_cnt_nxt_s;
      if (vinit_nxt_s) begin
        hoff_r <= hs_adj;
        voff_r <= vs_adj;
      end
    end
  end

  // Render look-ahead, mirrored about the active range when flipped
  always_comb begin
    n1_s = {1'b0, vdump} + 10'd1;
    n2_s = n1_s + 10'd1;
    if ({1'b0, vdump} == V_END_W) begin
      n1_s = V_START_W;
    end else begin
      n1_s = {1'b0, vdump} + 10'd1;
    end
    if (n1_s == V_END_W) begin
      n2_s = V_START_W;
    end else begin
      n2_s = n1_s + 10'd1;
    end
    if (flip) begin
      vrender  = 9'(V_FLIP_W - n1_s);
      vrender1 = 9'(V_FLIP_W - n2_s);
    end else begin
      vrender  = n1_s[8:0];
      vrender1 = n2_s[8:0];
    end
  end

endmodule

// File: tb/tb_jtkiwi_vtimer_adj.sv
// Scoreboard bench: a frame-position model predicts each pixel's outputs, a monitor
// compares them whenever the DUT issues a pixel; cen patterns are checked every clk.
module tb_jtkiwi_vtimer_adj;

  localparam int HT = 48;    // line length of the shortened-line instances
  localparam int VST = 16;
  localparam int VEN = 279;
  localparam int VT = VEN - VST + 1;
  localparam logic [28:0] RST_V = {1'b0, 1'b0, 9'd0, 9'd16, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] hs_adj;
  logic [2:0] vs_adj;
  logic       flip;

  logic m_pxl2_cen, m_pxl_cen, m_Hinit, m_Vinit, m_LHBL, m_LVBL, m_HS, m_VS, m_frame;
  logic [8:0] m_hdump, m_vdump, m_vrender, m_vrender1;
  logic w_pxl2_cen, w_pxl_cen, w_Hinit, w_Vinit, w_LHBL, w_LVBL, w_HS, w_VS, w_frame;
  logic [8:0] w_hdump, w_vdump, w_vrender, w_vrender1;
  logic d_pxl2_cen, d_pxl_cen, d_Hinit, d_Vinit, d_LHBL, d_LVBL, d_HS, d_VS, d_frame;
  logic [8:0] d_hdump, d_vdump, d_vrender, d_vrender1;

  jtkiwi_vtimer_adj #(.CEN_N(1), .CEN_M(1), .WC(4), .H_MAX(47), .HB_START(31),
                      .HS_START(36), .HS_LEN(6)) u_main (
    .clk(clk), .rst_n(rst_n), .hs_adj(hs_adj), .vs_adj(vs_adj), .flip(flip),
    .pxl2_cen(m_pxl2_cen), .pxl_cen(m_pxl_cen), .hdump(m_hdump), .vdump(m_vdump),
    .vrender(m_vrender), .vrender1(m_vrender1), .Hinit(m_Hinit), .Vinit(m_Vinit),
    .LHBL(m_LHBL), .LVBL(m_LVBL), .HS(m_HS), .VS(m_VS), .frame(m_frame));

  jtkiwi_vtimer_adj #(.CEN_N(1), .CEN_M(1), .WC(4), .H_MAX(47), .HB_START(31),
                      .HS_START(44), .HS_LEN(8)) u_wrap (
    .clk(clk), .rst_n(rst_n), .hs_adj(4'd7), .vs_adj(3'd0), .flip(1'b0),
    .pxl2_cen(w_pxl2_cen), .pxl_cen(w_pxl_cen), .hdump(w_hdump), .vdump(w_vdump),
    .vrender(w_vrender), .vrender1(w_vrender1), .Hinit(w_Hinit), .Vinit(w_Vinit),
    .LHBL(w_LHBL), .LVBL(w_LVBL), .HS(w_HS), .VS(w_VS), .frame(w_frame));

  jtkiwi_vtimer_adj u_def (
    .clk(clk), .rst_n(rst_n), .hs_adj(hs_adj), .vs_adj(vs_adj), .flip(flip),
    .pxl2_cen(d_pxl2_cen), .pxl_cen(d_pxl_cen), .hdump(d_hdump), .vdump(d_vdump),
    .vrender(d_vrender), .vrender1(d_vrender1), .Hinit(d_Hinit), .Vinit(d_Vinit),
    .LHBL(d_LHBL), .LVBL(d_LVBL), .HS(d_HS), .VS(d_VS), .frame(d_frame));

  typedef struct {
    int h; int v;
    bit hi; bit vi; bit hb; bit vb; bit hs; bit vs; bit fr; bit whs; bit wvs;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   mh, mv, mhoff, mvoff, whoff;
  bit   mfr;

  function automatic int md(int a, int b);
    return ((a % b) + b) % b;
  endfunction

  // A pxl2 pulse lands on every clk where floor(c*N/M) steps; pxl on the even-numbered ones
  function automatic bit pxl2_at(int c, int n, int m);
    return (c > 0) && ((c * n) / m != ((c - 1) * n) / m);
  endfunction

  function automatic bit pxl_at(int c, int n, int m);
    return pxl2_at(c, n, m) && (((c * n) / m) % 2 == 0);
  endfunction

  function automatic bit sync_hs(int h, int hs0, int len);
    return md(h - hs0, HT) < len;
  endfunction

  // VS as a window of VS_LEN whole lines in linear frame position, starting at (vs0, hs0)
  function automatic bit sync_vs(int h, int v, int hs0, int voff);
    int vs0, lpos, spos;
    vs0  = VST + md(254 + voff - VST, VT);
    lpos = (v - VST) * HT + h;
    spos = (vs0 - VST) * HT + hs0;
    return md(lpos - spos, VT * HT) < 3 * HT;
  endfunction

  function automatic int next_line(int v, int k, bit f);
    int n;
    n = VST + md(v - VST + k, VT);
    return f ? (VST + VEN - n) : n;
  endfunction

  // Reference model: advances one pixel per expected pxl_cen and queues the outputs
  initial begin
    exp_t e;
    bit   ev;
    int   hs0, whs0;
    forever begin
      @(posedge clk);
      if (rst_n !== 1'b1) begin
        cyc = 0; mh = 0; mv = VST; mfr = 1'b0;
        mhoff = 0; mvoff = 0; whoff = 0;
        sbq.delete();
      end else begin
        ev  = pxl_at(cyc, 1, 1);
        cyc = cyc + 1;
        if (ev) begin
          mh = md(mh + 1, HT);
          if (mh == 0) mv = (mv == VEN) ? VST : mv + 1;
          hs0   = md(36 + mhoff, HT);
          whs0  = md(44 + whoff, HT);
          e.h   = mh;
          e.v   = mv;
          e.hi  = (mh == HT - 1);
          e.vi  = e.hi && (mv == VEN);
          if (e.vi) mfr = ~mfr;
          e.fr  = mfr;
          e.hb  = (mh <= 31);
          e.vb  = (mv >= VST) && (mv <= 239);
          e.hs  = sync_hs(mh, hs0, 6);
          e.vs  = sync_vs(mh, mv, hs0, mvoff);
          e.whs = sync_hs(mh, whs0, 8);
          e.wvs = sync_vs(mh, mv, whs0, 0);
          sbq.push_back(e);
          if (e.vi) begin
            mhoff = int'($signed(hs_adj));
            mvoff = int'($signed(vs_adj));
            whoff = 7;
          end
        end
      end
    end
  end

  // Monitor: cen patterns every clk, pixel outputs whenever the DUT has just stepped
  initial begin
    exp_t e;
    bit   prev_cen;
    logic [53:0] got_m, want_m;
    logic [19:0] got_w, want_w;
    prev_cen = 1'b0;
    forever begin
      @(negedge clk);
      checks = checks + 1;
      if ({m_pxl_cen, m_pxl2_cen} !== {pxl_at(cyc, 1, 1), pxl2_at(cyc, 1, 1)}) begin
        failures = failures + 1;
        $display("FAIL cen_main cyc=%0d got pxl/pxl2=%b%b want %b%b", cyc, m_pxl_cen, m_pxl2_cen,
                 pxl_at(cyc, 1, 1), pxl2_at(cyc, 1, 1));
      end
      checks = checks + 1;
      if ({d_pxl_cen, d_pxl2_cen} !== {pxl_at(cyc, 1, 4), pxl2_at(cyc, 1, 4)}) begin
        failures = failures + 1;
        $display("FAIL cen_default cyc=%0d got pxl/pxl2=%b%b want %b%b", cyc, d_pxl_cen, d_pxl2_cen,
                 pxl_at(cyc, 1, 4), pxl2_at(cyc, 1, 4));
      end
      if (prev_cen && (rst_n === 1'b1)) begin
        if (sbq.size() == 0) begin
          checks = checks + 1;
          failures = failures + 1;
          $display("FAIL sb_underflow got an unexpected pixel step h=%0d v=%0d want none", m_hdump, m_vdump);
        end else begin
          e = sbq.pop_front();
          got_m  = {m_hdump, m_vdump, m_vrender, m_vrender1, m_Hinit, m_Vinit, m_LHBL, m_LVBL,
                    m_HS, m_VS, m_frame, 8'd0};
          want_m = {9'(e.h), 9'(e.v), 9'(next_line(e.v, 1, flip)), 9'(next_line(e.v, 2, flip)),
                    e.hi, e.vi, e.hb, e.vb, e.hs, e.vs, e.fr, 8'd0};
          checks = checks + 1;
          if (got_m !== want_m) begin
            failures = failures + 1;
            $display("FAIL pix_main got h=%0d v=%0d vr=%0d vr1=%0d hi=%b vi=%b hb=%b vb=%b hs=%b vs=%b fr=%b want h=%0d v=%0d vr=%0d vr1=%0d hi=%b vi=%b hb=%b vb=%b hs=%b vs=%b fr=%b",
                     m_hdump, m_vdump, m_vrender, m_vrender1, m_Hinit, m_Vinit, m_LHBL, m_LVBL, m_HS, m_VS, m_frame,
                     e.h, e.v, next_line(e.v, 1, flip), next_line(e.v, 2, flip), e.hi, e.vi, e.hb, e.vb, e.hs, e.vs, e.fr);
          end
          got_w  = {w_hdump, w_vdump, w_HS, w_VS};
          want_w = {9'(e.h), 9'(e.v), e.whs, e.wvs};
          checks = checks + 1;
          if (got_w !== want_w) begin
            failures = failures + 1;
            $display("FAIL pix_wrap got h=%0d v=%0d hs=%b vs=%b want h=%0d v=%0d hs=%b vs=%b",
                     w_hdump, w_vdump, w_HS, w_VS, e.h, e.v, e.whs, e.wvs);
          end
        end
      end
      prev_cen = m_pxl_cen;
    end
  end

  task automatic chk_reset(input string nm, input logic [28:0] got);
    checks = checks + 1;
    if (got !== RST_V) begin
      failures = failures + 1;
      $display("FAIL %s got %h want %h", nm, got, RST_V);
    end
  endtask

  task automatic chk_all_reset();
    chk_reset("reset_main", {m_pxl2_cen, m_pxl_cen, m_hdump, m_vdump, m_Hinit, m_Vinit,
                             m_LHBL, m_LVBL, m_HS, m_VS, m_frame});
    chk_reset("reset_wrap", {w_pxl2_cen, w_pxl_cen, w_hdump, w_vdump, w_Hinit, w_Vinit,
                             w_LHBL, w_LVBL, w_HS, w_VS, w_frame});
    chk_reset("reset_default", {d_pxl2_cen, d_pxl_cen, d_hdump, d_vdump, d_Hinit, d_Vinit,
                                d_LHBL, d_LVBL, d_HS, d_VS, d_frame});
  endtask

  task automatic run(input int n, input bit rnd_adj, input bit rnd_flip);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #2;
      if (rnd_adj && ($urandom_range(0, 249) == 0)) begin
        hs_adj = 4'($urandom);
        vs_adj = 3'($urandom);
      end
      if (rnd_flip && ($urandom_range(0, 299) == 0)) flip = 1'($urandom);
    end
  endtask

  initial begin
    int w;
    rst_n  = 1'b0;
    hs_adj = 4'd0;
    vs_adj = 3'd0;
    flip   = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_reset();
    #2 rst_n = 1'b1;
    run(300, 1'b0, 1'b0);
    run(14700, 1'b1, 1'b1);
    // Mid-frame offset write: must only take effect from the next frame
    hs_adj = 4'hD;
    vs_adj = 3'd2;
    run(15000, 1'b0, 1'b1);
    run(23000, 1'b1, 1'b1);
    w = 0;
    while (!(m_LHBL && m_LVBL && (m_hdump >= 9'd5) && (m_hdump <= 9'd20)) && (w < 2000)) begin
      @(negedge clk);
      #2;
      w = w + 1;
    end
    checks = checks + 1;
    if (w >= 2000) begin
      failures = failures + 1;
      $display("FAIL wait_active_line got timeout after %0d cycles want an active line", w);
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk_all_reset();
    #2 rst_n = 1'b1;
    run(3000, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    checks = checks + 1;
    if (sbq.size() != 0) begin
      failures = failures + 1;
      $display("FAIL sb_leftover got %0d pending pixels want 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtkiwi_vtimer_adj.md
Name: jtkiwi_vtimer_adj

Overview:
- Parametrised video timing generator for the kiwi family and its successors.
- Merges fractional pixel clock-enable generation with H/V counting, blanking, sync and render look-ahead.
- Adds run-time H/V sync position adjustment, applied only at frame boundaries.
- Feeds the gfx and colmix blocks inside the video top level.

Parameters:
CEN_N, 1, pxl2_cen numerator
CEN_M, 4, pxl2_cen denominator (pxl2_cen rate = clk*CEN_N/CEN_M); CEN_N<=CEN_M required
WC, 4, fractional accumulator width; must hold CEN_M+CEN_N-1
H_MAX, 383, last hdump value; hdump wraps H_MAX->0
HB_START, 255, last active pixel; LHBL=1 for hdump<=HB_START
HS_START, 297, nominal HS rising position
HS_LEN, 32, HS width in pixels
V_START, 16, first line; vdump wraps V_END->V_START
V_END, 279, last line
VB_START, 239, last active line; LVBL=1 for V_START<=vdump<=VB_START
VS_START, 254, nominal VS first line
VS_LEN, 3, VS height in lines

Ports:
clk  in  1  system clock, 48 MHz
rst_n  in  1  synchronous reset, active-low
hs_adj  in  4  signed HS shift in pixels (-8..+7)
vs_adj  in  3  signed VS shift in lines (-4..+3)
flip  in  1  screen flip, affects vrender/vrender1 only
pxl2_cen  out  1  double-rate pixel enable
pxl_cen  out  1  pixel enable
hdump  out  9  horizontal count
vdump  out  9  current line
vrender  out  9  next line (flip-aware)
vrender1  out  9  line after next (flip-aware)
Hinit  out  1  one-pxl_cen pulse at hdump==H_MAX
Vinit  out  1  pulse at hdump==H_MAX and vdump==V_END
LHBL  out  1  horizontal active, high = active
LVBL  out  1  vertical active, high = active
HS  out  1  horizontal sync, active high
VS  out  1  vertical sync, active high
frame  out  1  toggles at each Vinit

Behaviour:
- Reset (rst_n=0 at a clk edge) sets:
  - acc=0, pxl2_cen=0, pxl_cen=0, hdump=0, vdump=V_START;
  - Hinit=Vinit=HS=VS=frame=0, LHBL=1, LVBL=1;
  - latched offsets = 0.
  - Reset mid-frame restarts counting from that state on the next enabled cycle.
- Clock-enable generation:
  - Each clk: if acc+CEN_N >= CEN_M then acc <= acc+CEN_N-CEN_M and pxl2_cen <= 1; else acc <= acc+CEN_N and pxl2_cen <= 0.
  - A toggle flips on every pxl2_cen pulse; pxl_cen is driven on pulses where the toggle was 1, giving a 1-cycle pulse on every second pxl2 pulse.
  - Defaults: pxl2_cen every 4th clk, pxl_cen every 8th clk. The first pxl2_cen comes 4 clks after reset release; the first pxl_cen comes at the second pxl2_cen.
- Counting: all outputs except the cens change only on clk edges with pxl_cen=1.
  - hdump increments and wraps H_MAX->0.
  - vdump increments when hdump wraps, and wraps V_END->V_START.
- Look-ahead:
  - flip=0: vrender=vdump+1 and vrender1=vdump+2, each wrapping within [V_START,V_END] (V_END+1 maps to V_START).
  - flip=1: both values are mirrored as V_START+V_END-x.
  - Both are combinational from vdump and flip.
- Blanking: LHBL and LVBL are registered from the next hdump/vdump values, so they align with hdump/vdump.
- Offsets:
  - hs_adj and vs_adj are sampled into sign-extended latches only on the pxl_cen edge where Vinit asserts. Changes mid-frame have no effect until the next frame.
  - Effective HS start hs0 = HS_START+hoff, modulo H_MAX+1. Effective VS start vs0 = VS_START+voff, kept within [V_START,V_END] by wrapping.
- Sync generation:
  - HS=1 for HS_LEN pixels starting at hdump==hs0, with wrap past H_MAX allowed.
  - VS rises at hdump==hs0 on line vs0 and falls at hdump==hs0 on line vs0+VS_LEN, wrapping.
  - When an offset change moves vs0 while VS=1, VS still completes its VS_LEN lines.
- Hinit, Vinit and frame:
  - Hinit and Vinit are registered; each lasts one pxl_cen period.
  - frame toggles on the same edge Vinit rises.
- Widths: all compare arithmetic is 10 bits to avoid overflow at the wrap points.

Test Plan:
- Release rst_n with default parameters: pxl2_cen pulses at clk 4, 8, 12...; pxl_cen at clk 8, 16...; no other cen pattern appears.
- Run 2 frames: 384 pxl_cen per line and 264 lines per frame.
  - LHBL high for hdump 0..255.
  - LVBL high for vdump 16..239.
  - Vinit pulses once per frame at hdump=383, vdump=279.
  - frame toggles once per frame.
- hs_adj=-3 and vs_adj=+2 written mid-frame: current frame keeps HS rise at hdump 297 and VS at line 254. Next frame has HS at 294..325 and VS from line 256, hdump 294, for 3 lines.
- hs_adj=+7 with HS_START=380: HS wraps, high for hdump 3..34; vdump must not skip or double.
- flip=1 at vdump=16: vrender=278, vrender1=277. With flip=0 at vdump=279: vrender=16, vrender1=17.
- Assert rst_n=0 for 1 clk mid-active-line: next cycle all outputs equal their reset values, and counting resumes from hdump=0, vdump=16.
